// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR post-processing chain.
package fir_pkg;
    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] sample_t;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word: dout is valid the cycle after the
// word becomes the head, with no combinational path from din to dout.
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      pop,
    output logic [DATA_W-1:0]         dout,
    output logic [clog2_f(DEPTH):0]   level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = clog2_f(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     rd_ptr_next;
    logic [AW:0]       level_reg;
    logic [DATA_W-1:0] head_reg;
    logic              do_push;
    logic              do_pop;

    assign full        = (level_reg == (AW+1)'(DEPTH));
    assign empty       = (level_reg == '0);
    assign do_pop      = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push     = push && (!full || do_pop);
    assign rd_ptr_next = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            // The incoming word becomes head directly when nothing older remains.
            if (do_push && (empty || (do_pop && level_reg == (AW+1)'(1)))) begin
                head_reg <= din;
            end else if (do_pop) begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign dout  = head_reg;
    assign level = level_reg;
endmodule

// File: rtl/fir_decim_avg_buffer.sv
// Block-averages DECIM consecutive FIR samples (round-half-up) and buffers the
// decimated results in a FIFO with a valid/ready read port and sticky overflow flag.
module fir_decim_avg_buffer
    import fir_pkg::*;
#(
    parameter int DATA_W = fir_pkg::DATA_W,
    parameter int DECIM  = 4,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [clog2_f(DEPTH):0]   level,
    output logic                      overflow,
    input  logic                      clear_ovf
);
    localparam int LOG2_D = clog2_f(DECIM);
    localparam int PH_W   = (LOG2_D > 0) ? LOG2_D : 1;
    localparam int ACC_W  = DATA_W + LOG2_D;

    logic [PH_W-1:0]         phase_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rounded;
    logic [DATA_W-1:0]       avg;
    logic                    last;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    drop;
    logic                    overflow_reg;

    assign in_ext  = ACC_W'($signed(in_data));
    assign last    = (phase_reg == PH_W'(DECIM - 1));
    // Phase 0 starts a fresh group, so the stale accumulator is ignored there.
    assign sum     = (phase_reg == '0) ? in_ext : (acc_reg + in_ext);
    // The rounded sum cannot overflow ACC_W: the +DECIM/2 bias never exceeds DECIM-1.
    assign rounded = (sum + ACC_W'(DECIM / 2)) >>> LOG2_D;
    assign avg     = DATA_W'(rounded);
    assign push    = in_valid && last;
    assign pop     = out_valid && out_ready;
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_reg    <= '0;
            acc_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (in_valid) begin
                acc_reg   <= sum;
                phase_reg <= last ? '0 : phase_reg + 1'b1;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (avg),
        .pop    (pop),
        .dout   (out_data),
        .level  (level),
        .full   (full),
        .empty  (empty)
    );

    assign out_valid = !empty;
    assign overflow  = overflow_reg;
endmodule

// File: tb/tb_fir_decim_avg_buffer.sv
// Drives a DECIM=4 and a DECIM=1 instance with identical stimulus and checks both
// against a group-sum/queue reference model every cycle.
module tb_fir_decim_avg_buffer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clear_ovf;

    logic        ov4, ov1, ovf4, ovf1;
    logic [15:0] od4, od1;
    logic [3:0]  lv4, lv1;

    int checks   = 0;
    int failures = 0;

    int grp_cnt [2];
    int grp_sum [2];
    int mq      [2][$];
    bit m_ovf   [2];
    int dec     [2] = '{4, 1};

    always #5 clk = ~clk;

    fir_decim_avg_buffer #(.DATA_W(16), .DECIM(4), .DEPTH(8)) dut4 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .level(lv4),
        .overflow(ovf4), .clear_ovf(clear_ovf)
    );

    fir_decim_avg_buffer #(.DATA_W(16), .DECIM(1), .DEPTH(8)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .level(lv1),
        .overflow(ovf1), .clear_ovf(clear_ovf)
    );

    function automatic int floor_div(input int n, input int d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model(input int i, input bit rst, input bit v, input int d,
                         input bit rdy, input bit clr);
        bit pop, push, drop;
        int r;
        if (rst) begin
            grp_cnt[i] = 0;
            grp_sum[i] = 0;
            mq[i].delete();
            m_ovf[i] = 0;
            return;
        end
        pop  = (mq[i].size() > 0) && rdy;
        push = 0;
        r    = 0;
        if (v) begin
            grp_sum[i] += d;
            grp_cnt[i]++;
            if (grp_cnt[i] == dec[i]) begin
                push = 1;
                r = floor_div(grp_sum[i] + dec[i] / 2, dec[i]);
                grp_cnt[i] = 0;
                grp_sum[i] = 0;
            end
        end
        drop = push && (mq[i].size() == 8) && !pop;
        if (pop) $display("decim=%0d pop data=%0d", dec[i], mq[i].pop_front());
        if (push && !drop) mq[i].push_back(r);
        if (drop) m_ovf[i] = 1;
        else if (clr) m_ovf[i] = 0;
    endtask

    task automatic check_one(input int i, input bit rst, input logic ov, input logic [15:0] od,
                             input logic [3:0] lv, input logic of);
        string p;
        p = $sformatf("d%0d", dec[i]);
        chk({p, ".out_valid"}, {31'd0, ov}, (mq[i].size() != 0) ? 1 : 0);
        chk({p, ".level"}, {28'd0, lv}, mq[i].size());
        chk({p, ".overflow"}, {31'd0, of}, m_ovf[i] ? 1 : 0);
        if (rst) chk({p, ".out_data_rst"}, $signed(od), 0);
        else if (mq[i].size() != 0) chk({p, ".out_data"}, $signed(od), mq[i][0]);
    endtask

    task automatic cycle(input bit rst, input bit v, input int d, input bit rdy, input bit clr);
        resetn    = !rst;
        in_valid  = v;
        in_data   = 16'(d);
        out_ready = rdy;
        clear_ovf = clr;
        model(0, rst, v, d, rdy, clr);
        model(1, rst, v, d, rdy, clr);
        @(posedge clk);
        #1;
        check_one(0, rst, ov4, od4, lv4, ovf4);
        check_one(1, rst, ov1, od1, lv1, ovf1);
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_ovf = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 77, 1, 0);

        // 10,20,30,41 -> 25, visible one cycle after the 4th input
        cycle(0, 1, 10, 1, 0);
        cycle(0, 1, 20, 1, 0);
        cycle(0, 1, 30, 1, 0);
        chk("plan.avg25_early", {31'd0, ov4}, 0);
        cycle(0, 1, 41, 1, 0);
        chk("plan.avg25_valid", {31'd0, ov4}, 1);
        chk("plan.avg25_data", $signed(od4), 25);
        cycle(0, 0, 0, 1, 0);
        chk("plan.avg25_one_cycle", {31'd0, ov4}, 0);

        // Negative rounding and extremes
        cycle(0, 1, -1, 1, 0);
        cycle(0, 1, -2, 1, 0);
        cycle(0, 1, -2, 1, 0);
        cycle(0, 1, -2, 1, 0);
        chk("plan.neg_round", $signed(od4), -2);
        for (int k = 0; k < 4; k++) cycle(0, 1, 32767, 1, 0);
        chk("plan.max", $signed(od4), 32767);
        for (int k = 0; k < 4; k++) cycle(0, 1, -32768, 1, 0);
        chk("plan.min", $signed(od4), -32768);

        // DECIM=1 pass-through with gaps
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 5, 1, 0);
        chk("plan.pass5", $signed(od1), 5);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, -7, 1, 0);
        chk("plan.pass_m7", $signed(od1), -7);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 9, 1, 0);
        chk("plan.pass9", $signed(od1), 9);

        // Fill DECIM=1 FIFO, overflow on the 9th
        cycle(1, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) cycle(0, 1, k, 0, 0);
        chk("plan.full_level", {28'd0, lv1}, 8);
        chk("plan.full_ovf", {31'd0, ovf1}, 1);
        chk("plan.full_head", $signed(od1), 1);
        cycle(0, 1, 10, 0, 1);
        chk("plan.drop_and_clear", {31'd0, ovf1}, 1);
        cycle(0, 0, 0, 0, 1);
        chk("plan.clear_alone", {31'd0, ovf1}, 0);
        cycle(0, 1, 11, 1, 0);
        chk("plan.push_pop_full_level", {28'd0, lv1}, 8);
        chk("plan.push_pop_full_ovf", {31'd0, ovf1}, 0);
        for (int k = 0; k < 9; k++) cycle(0, 0, 0, 1, 0);

        // Reset mid-group discards the partial sum
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 100, 1, 0);
        cycle(0, 1, 100, 1, 0);
        cycle(1, 0, 0, 1, 0);
        chk("plan.rst_level", {28'd0, lv4}, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 4, 1, 0);
        chk("plan.rst_result", $signed(od4), 4);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  int'($signed(16'($urandom))),
                  ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
